// File: rtl/riscv_fetch_queue.sv
// rtl/riscv_fetch_queue.sv - instruction fetch front end: PC, icache handshake, fetch FIFO, redirect flush
// Optional same-cycle response-to-decode bypass when FETCH_QUEUE_BYPASS_EN is defined.
module riscv_fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h2000,
    parameter logic [31:0] NOP       = 32'h13
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] icache_addr,
    output logic        icache_re,
    input  logic        icache_req_ready,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_dout,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [OW-1:0] outst, outst_next, drop;
    logic [TW-1:0] tag_rd, tag_wr;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] tag_mem   [MAX_OUTST];

    logic accept, resp_take, bypass_hit, push, pop;

    // Tag FIFO depth need not be a power of two, so wrap explicitly.
    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (int'(p) == MAX_OUTST - 1) ? '0 : p + 1'b1;
    endfunction

    assign icache_addr = fetch_pc;
    assign icache_re   = !reset && !redirect_valid
                         && ((int'(count) + int'(outst)) < DEPTH)
                         && (int'(outst) < MAX_OUTST);
    assign accept      = icache_re && icache_req_ready;
    assign resp_take   = icache_resp_valid && !redirect_valid && (drop == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_hit = resp_take && (count == '0);
`else
    assign bypass_hit = 1'b0;
`endif

    assign push = resp_take && !(bypass_hit && out_ready);
    assign pop  = (count != '0) && out_ready && !redirect_valid;

    always_comb begin
        outst_next = outst;
        if (accept && !icache_resp_valid)
            outst_next = outst + 1'b1;
        else if (!accept && icache_resp_valid)
            outst_next = outst - 1'b1;
    end

    always_comb begin
        out_valid = 1'b0;
        out_instr = NOP;
        out_pc    = fetch_pc;
        if (count != '0) begin
            out_valid = 1'b1;
            out_instr = instr_mem[rd_ptr];
            out_pc    = pc_mem[rd_ptr];
        end else if (bypass_hit) begin
            out_valid = 1'b1;
            out_instr = icache_dout;
            out_pc    = tag_mem[tag_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            outst    <= '0;
            drop     <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
        end else begin
            outst <= outst_next;
            if (redirect_valid) begin
                // Everything still in flight belongs to the old path and must be discarded.
                fetch_pc <= redirect_pc;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                tag_rd   <= '0;
                tag_wr   <= '0;
                drop     <= outst_next;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    tag_wr   <= tag_inc(tag_wr);
                end
                if (resp_take)
                    tag_rd <= tag_inc(tag_rd);
                if (icache_resp_valid && drop != '0)
                    drop <= drop - 1'b1;
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)
                    count <= count + 1'b1;
                else if (pop && !push)
                    count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !redirect_valid && accept)
            tag_mem[tag_wr] <= fetch_pc;
        if (!reset && push) begin
            instr_mem[wr_ptr] <= icache_dout;
            pc_mem[wr_ptr]    <= tag_mem[tag_rd];
        end
    end
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// tb/tb_riscv_fetch_queue.sv - scoreboard bench for riscv_fetch_queue
module tb_riscv_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h2000;
    localparam logic [31:0] NOP      = 32'h13;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic        icache_req_ready;
    logic        icache_resp_valid;
    logic [31:0] icache_dout;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    riscv_fetch_queue dut (
        .clk(clk), .reset(reset),
        .icache_addr(icache_addr), .icache_re(icache_re),
        .icache_req_ready(icache_req_ready), .icache_resp_valid(icache_resp_valid),
        .icache_dout(icache_dout), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; int due; } req_t;
    req_t        resp_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] mpc = RESET_PC;
    logic [31:0] popped_pc = '0;
    int cyc = 0, last_due = -1, pops = 0, max_delay = 1;
    int n_checks = 0, n_pass = 0;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        if (pc == 32'h2000) return 32'h00500093;
        return {pc[7:0], 8'h5a, pc[15:8], 8'hc3};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
            icache_resp_valid = 1'b1;
            icache_dout       = word_of(resp_q[0].pc);
        end else begin
            icache_resp_valid = 1'b0;
            icache_dout       = 32'hdeadbeef;
        end
    endtask

    task automatic wait_pop_pc(input string tag, input logic [31:0] exp_pc);
        int start = pops;
        for (int i = 0; i < 40 && pops == start; i++) step();
        check_eq({tag, "_seen"}, 64'(pops > start), 64'd1);
        check_eq(tag, {32'd0, popped_pc}, {32'd0, exp_pc});
    endtask

    // Scoreboard: expected words are queued at request accept and compared at consumption.
    always @(negedge clk) begin
        if (!reset) begin
            if (!out_valid) check_eq("nop_idle", {32'd0, out_instr}, {32'd0, NOP});
            if (out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) check_eq("spurious_pop", {out_pc, out_instr}, 64'd0);
                else check_eq("head", {out_pc, out_instr}, exp_q.pop_front());
                popped_pc = out_pc;
                pops++;
            end
            if (redirect_valid) begin
                check_eq("re_on_redirect", {63'd0, icache_re}, 64'd0);
                exp_q.delete();
                mpc = redirect_pc;
            end
            if (icache_re) check_eq("addr", {32'd0, icache_addr}, {32'd0, mpc});
            if (icache_resp_valid && resp_q.size() > 0) void'(resp_q.pop_front());
            if (icache_re && icache_req_ready) begin
                req_t r;
                int d = $urandom_range(max_delay, 1);
                r.pc  = mpc;
                r.due = (cyc + d > last_due) ? cyc + d : last_due + 1;
                last_due = r.due;
                resp_q.push_back(r);
                exp_q.push_back({mpc, word_of(mpc)});
                mpc = mpc + 32'd4;
            end
        end
    end

    initial begin
        reset = 1'b1; icache_req_ready = 1'b1; icache_resp_valid = 1'b0; icache_dout = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        repeat (3) step();
        check_eq("rst_re", {63'd0, icache_re}, 64'd0);
        check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_instr", {32'd0, out_instr}, {32'd0, NOP});
        check_eq("rst_pc", {32'd0, out_pc}, {32'd0, RESET_PC});
        check_eq("rst_addr", {32'd0, icache_addr}, {32'd0, RESET_PC});

        // Streaming with 1-cycle responses, plus response-to-decode latency.
        reset = 1'b0;
        for (int i = 0; i < 10 && !icache_resp_valid; i++) step();
        #1 check_eq("lat_first", {63'd0, out_valid}, {63'd0, BYP});
        check_eq("lat_first_pc", {32'd0, (BYP ? out_pc : 32'h2000)}, 64'h2000);
        step();
        #1 check_eq("lat_next", {63'd0, out_valid}, 64'd1);
        repeat (30) step();

        // Decode stalled: exactly DEPTH entries buffered, fetch stops.
        out_ready = 1'b0;
        repeat (20) step();
        check_eq("full_re", {63'd0, icache_re}, 64'd0);
        check_eq("full_valid", {63'd0, out_valid}, 64'd1);
        check_eq("full_count", 64'(exp_q.size()), 64'(DEPTH));
        out_ready = 1'b1;
        repeat (10) step();

        // Redirect with two requests outstanding.
        max_delay = 3;
        repeat (10) step();
        redirect_valid = 1'b1; redirect_pc = 32'h3000;
        step();
        redirect_valid = 1'b0;
        #1 check_eq("flush_empty", {63'd0, out_valid}, 64'd0);
        wait_pop_pc("redir_3000", 32'h3000);
        repeat (10) step();

        // Redirect colliding with response and pop, then immediately overridden.
        max_delay = 1;
        repeat (8) step();
        check_eq("collide_setup", {62'd0, icache_resp_valid, out_valid}, 64'd3);
        redirect_valid = 1'b1; redirect_pc = 32'h3000;
        step();
        redirect_pc = 32'h4000;
        step();
        redirect_valid = 1'b0;
        wait_pop_pc("redir_4000", 32'h4000);

        // Random traffic: toggling req_ready, 1-3 cycle responses, random stalls and redirects.
        max_delay = 3;
        for (int i = 0; i < 400; i++) begin
            step();
            icache_req_ready = (i % 2 == 0);
            out_ready        = ($urandom_range(3, 0) != 0);
            redirect_valid   = ($urandom_range(39, 0) == 0);
            redirect_pc      = 32'h5000 + {$urandom_range(255, 0), 2'b00};
        end
        step();
        redirect_valid = 1'b0; icache_req_ready = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || resp_q.size() != 0); i++) step();
        check_eq("drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
